// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared stopwatch state encodings and count constants
// SW_LAP_EN adds the LAP state encoding.
package sw_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
`ifdef SW_LAP_EN
    , ST_LAP = 2'd3
`endif
  } sw_state_e;

endpackage

// File: rtl/sw_tick_gen.sv
// rtl/sw_tick_gen.sv - 32-bit tick divider with enable, clear and held phase
// The count holds while disabled so a resume keeps its phase.
module sw_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [31:0] num_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d, limit;

  // Using >= lets a lowered num take effect without counting past it.
  always_comb begin
    limit  = (num_i == 32'd0) ? 32'd0 : num_i - 32'd1;
    tick_o = enable_i && !clear_i && (cnt_q >= limit);
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sw_ctrl.sv
// rtl/sw_ctrl.sv - stopwatch run/pause/clear/lap FSM with mm:ss counters
// SW_LAP_EN enables the LAP state, lap snapshot registers and display mux.
module sw_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num,
  input  logic        i_start_stop,
  input  logic        i_clear,
  input  logic        i_lap,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic        o_run,
  output logic        o_tick
);

  import sw_pkg::*;

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d, min_q, min_d;
  logic [CNT_W-1:0] disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic             run_q, run_d, tick_q;
  logic             div_en, div_clr, tick;

`ifdef SW_LAP_EN
  logic [CNT_W-1:0] lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
  logic             lap_cap;
`else
  logic unused_lap;
  assign unused_lap = i_lap;
`endif

  sw_tick_gen u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (div_en),
    .clear_i  (div_clr),
    .num_i    (num),
    .tick_o   (tick)
  );

  // Priority: clear, then start/stop, then lap.
  always_comb begin
    state_d = state_q;
    div_clr = 1'b0;
`ifdef SW_LAP_EN
    lap_cap = 1'b0;
`endif
    if (i_clear) begin
      state_d = ST_IDLE;
      div_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start_stop) begin
            state_d = ST_RUN;
            div_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (i_start_stop) begin
            state_d = ST_PAUSE;
          end
`ifdef SW_LAP_EN
          else if (i_lap) begin
            state_d = ST_LAP;
            lap_cap = 1'b1;
          end
`endif
        end
        ST_PAUSE: begin
          if (i_start_stop) begin
            state_d = ST_RUN;
          end
        end
`ifdef SW_LAP_EN
        ST_LAP: begin
          if (i_start_stop) begin
            state_d = ST_PAUSE;
          end else if (i_lap) begin
            state_d = ST_RUN;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef SW_LAP_EN
    div_en = (state_q == ST_RUN) || (state_q == ST_LAP);
    run_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
`else
    div_en = (state_q == ST_RUN);
    run_d  = (state_d == ST_RUN);
`endif
    sec_d = sec_q;
    min_d = min_q;
    if (i_clear) begin
      sec_d = '0;
      min_d = '0;
    end else if (tick) begin
      if (sec_q == CNT_MAX) begin
        sec_d = '0;
        min_d = (min_q == CNT_MAX) ? '0 : min_q + 6'd1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Snapshot takes the pre-advance live value; display follows the next state.
  always_comb begin
    disp_sec_d = sec_d;
    disp_min_d = min_d;
`ifdef SW_LAP_EN
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    if (i_clear) begin
      lap_sec_d = '0;
      lap_min_d = '0;
    end else if (lap_cap) begin
      lap_sec_d = sec_q;
      lap_min_d = min_q;
    end
    if (state_d == ST_LAP) begin
      disp_sec_d = lap_sec_d;
      disp_min_d = lap_min_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sec_q      <= '0;
      min_q      <= '0;
      disp_sec_q <= '0;
      disp_min_q <= '0;
      run_q      <= 1'b0;
      tick_q     <= 1'b0;
`ifdef SW_LAP_EN
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
      run_q      <= run_d;
      tick_q     <= tick;
`ifdef SW_LAP_EN
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
`endif
    end
  end

  assign o_sec  = disp_sec_q;
  assign o_min  = disp_min_q;
  assign o_run  = run_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// tb/tb_sw_ctrl.sv - directed self-checking bench for sw_ctrl
// The lap sequence runs only when SW_LAP_EN is defined.
module tb_sw_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic        i_start_stop;
  logic        i_clear;
  logic        i_lap;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic        o_run;
  logic        o_tick;

  int errors = 0;
  int checks = 0;

  sw_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .num          (num),
    .i_start_stop (i_start_stop),
    .i_clear      (i_clear),
    .i_lap        (i_lap),
    .o_sec        (o_sec),
    .o_min        (o_min),
    .o_run        (o_run),
    .o_tick       (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n active edges; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input int sec, input int min, input bit run, input bit tck);
    chk({tag, ".sec"},  32'(o_sec),  32'(sec));
    chk({tag, ".min"},  32'(o_min),  32'(min));
    chk({tag, ".run"},  32'(o_run),  32'(run));
    chk({tag, ".tick"}, 32'(o_tick), 32'(tck));
  endtask

  task automatic pulse_start();
    i_start_stop = 1'b1;
    cyc(1);
    i_start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    cyc(1);
    i_clear = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    num          = 32'd4;
    i_start_stop = 1'b0;
    i_clear      = 1'b0;
    i_lap        = 1'b0;

    // Reset, then start with num=4: ticks at cycles 5, 9, 13.
    cyc(3);
    chk_all("reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    pulse_start();
    chk_all("start.c1", 0, 0, 1'b1, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      cyc(1);
      chk("start.tick", 32'(o_tick), ((e % 4) == 0) ? 32'd1 : 32'd0);
      chk("start.sec", 32'(o_sec), 32'(e / 4));
      chk("start.run", 32'(o_run), 32'd1);
    end

    // Pause two cycles after a tick, hold ten, resume: next tick two counting cycles later.
    pulse_clear();
    chk_all("clear", 0, 0, 1'b0, 1'b0);
    num = 32'd4;
    pulse_start();
    cyc(4);
    chk_all("pr.tick1", 1, 0, 1'b1, 1'b1);
    cyc(1);
    pulse_start();
    chk_all("pr.paused", 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pr.hold.sec", 32'(o_sec), 32'd1);
      chk("pr.hold.tick", 32'(o_tick), 32'd0);
    end
    pulse_start();
    chk_all("pr.resume", 1, 0, 1'b1, 1'b0);
    cyc(1);
    chk_all("pr.resume+1", 1, 0, 1'b1, 1'b0);
    cyc(1);
    chk_all("pr.resume+2", 2, 0, 1'b1, 1'b1);

    // Clear and start/stop together in RUN: clear wins.
    i_clear      = 1'b1;
    i_start_stop = 1'b1;
    cyc(1);
    i_clear      = 1'b0;
    i_start_stop = 1'b0;
    chk_all("clr+ss", 0, 0, 1'b0, 1'b0);
    cyc(5);
    chk_all("clr+ss.idle", 0, 0, 1'b0, 1'b0);

    // Start/stop and lap together in RUN: pause, no lap.
    pulse_start();
    cyc(4);
    chk("ss+lap.pre", 32'(o_sec), 32'd1);
    cyc(1);
    i_start_stop = 1'b1;
    i_lap        = 1'b1;
    cyc(1);
    i_start_stop = 1'b0;
    i_lap        = 1'b0;
    chk_all("ss+lap", 1, 0, 1'b0, 1'b0);
    cyc(4);
    chk_all("ss+lap.hold", 1, 0, 1'b0, 1'b0);
    pulse_start();
    cyc(2);
    chk_all("ss+lap.live", 2, 0, 1'b1, 1'b1);

    // Full wrap with num=1.
    pulse_clear();
    num = 32'd1;
    pulse_start();
    cyc(59);
    chk_all("wrap.0059", 59, 0, 1'b1, 1'b1);
    cyc(1);
    chk_all("wrap.0100", 0, 1, 1'b1, 1'b1);
    cyc(3539);
    chk_all("wrap.5959", 59, 59, 1'b1, 1'b1);
    cyc(1);
    chk_all("wrap.0000", 0, 0, 1'b1, 1'b1);

    // num=0 behaves as 1.
    pulse_clear();
    num = 32'd0;
    pulse_start();
    cyc(3);
    chk_all("num0", 3, 0, 1'b1, 1'b1);

`ifdef SW_LAP_EN
    // Lap at 00:07 with num=2, five ticks, then unlap shows 00:12.
    pulse_clear();
    num = 32'd2;
    pulse_start();
    cyc(14);
    chk("lap.pre", 32'(o_sec), 32'd7);
    i_lap = 1'b1;
    cyc(1);
    i_lap = 1'b0;
    chk_all("lap.enter", 7, 0, 1'b1, 1'b0);
    for (int e = 16; e <= 24; e++) begin
      cyc(1);
      chk("lap.frozen", 32'(o_sec), 32'd7);
      chk("lap.tick", 32'(o_tick), ((e % 2) == 0) ? 32'd1 : 32'd0);
    end
    i_lap = 1'b1;
    cyc(1);
    i_lap = 1'b0;
    chk_all("lap.exit", 12, 0, 1'b1, 1'b0);
`endif

    // Mid-run reset with num=1.
    pulse_clear();
    num = 32'd1;
    pulse_start();
    cyc(5);
    chk_all("mrst.pre", 5, 0, 1'b1, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk_all("mrst", 0, 0, 1'b0, 1'b0);
    cyc(3);
    chk_all("mrst.idle", 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_ctrl.md
# sw_ctrl

Stopwatch controller that sequences the tick divider and the two modulo-60 time counters (seconds, minutes) from three single-cycle button pulses. It owns the run/pause/clear/lap state machine, gates the divider, and selects whether the display shows the live count or a frozen lap snapshot. It sits between the button debouncers and the display driver, replacing a free-running divider-plus-counter pair.

## Interface
- CNT_MAX, 59: terminal value of both the seconds and minutes counters; each wraps CNT_MAX→0.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- num  input  32  clk cycles per tick; 0 is treated as 1.
- i_start_stop  input  1  one-cycle pulse: toggle run/pause.
- i_clear  input  1  one-cycle pulse: return to IDLE with zero counts.
- i_lap  input  1  one-cycle pulse: freeze/unfreeze the display while counting continues.
- o_sec  output  6  displayed seconds, 0..CNT_MAX.
- o_min  output  6  displayed minutes, 0..CNT_MAX.
- o_run  output  1  high while counting (RUN or LAP).
- o_tick  output  1  one-cycle pulse in the cycle the live count advances.

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset state IDLE.
- Input priority when pulses coincide: i_clear > i_start_stop > i_lap; lower-priority pulses in the same cycle are dropped.
- i_clear in any state: go to IDLE; live sec/min, lap registers and divider count all zeroed.
- IDLE: i_start_stop → RUN with divider count 0; i_lap ignored.
- RUN: i_start_stop → PAUSE; i_lap → LAP, capturing live sec/min into the lap registers on the same edge.
- LAP: counting continues and the display shows the lap registers. i_lap → RUN (display live). i_start_stop → PAUSE (display live).
- PAUSE: divider and counters hold. i_start_stop → RUN, resuming the divider from its held count (no phase loss). i_lap ignored.
- Divider: in RUN/LAP, cnt increments each cycle. When cnt ≥ max(num,1)−1: cnt←0 and the live count advances. The ≥ compare makes a mid-run decrease of num take effect without overrun.
- Live count advance: sec←sec+1. If sec==CNT_MAX, sec←0 and min←min+1. If min==CNT_MAX as well, min←0 (full wrap 59:59→00:00).
- o_sec/o_min show the lap registers in LAP and the live registers in every other state.

## Timing
- Reset values: o_sec=0, o_min=0, o_run=0, o_tick=0, state IDLE, divider cnt=0.
- Reset mid-operation has the same effect as i_clear and also forces o_tick=0.
- All outputs are registered.
- A button pulse sampled at edge k changes state at edge k; o_run reflects the new state in cycle k+1.
- After a start at edge 0 from IDLE with num=N, the first advance occurs at edge N. o_tick is high in cycle N+1, which is also the first cycle showing the new count.
- Ticks then repeat every N cycles while counting. With num=0 or 1, the count advances on every counting cycle.
- Lap capture uses the live value before any advance at the same edge; a tick coincident with i_lap is counted live but is not in the snapshot.
- A tick coincident with i_start_stop in RUN is counted, and the count then holds.
- o_tick stays low in IDLE and PAUSE.

## Configuration
- SW_LAP_EN defined: LAP state, lap registers and display mux are present as described.
- SW_LAP_EN undefined: i_lap is ignored and the LAP state does not exist. The display always shows the live count.

## Structure
- Shared package sw_pkg holds the state enum (IDLE, RUN, PAUSE, LAP encodings) and the 6-bit count width constant.
- One sub-module, sw_tick_gen, is the 32-bit divider. It has inputs enable and clear, and outputs a tick strobe. Synchronous active-low reset.
- FSM, counters, lap registers and output mux stay in sw_ctrl.

## Test plan
- Reset and start: rst_n low 3 cycles, then num=4 and i_start_stop at edge 0. Required: o_run=1 from cycle 1, o_tick at cycles 5, 9, 13, and o_sec=1, 2, 3 on those cycles.
- Pause and resume: num=4. Pause 2 cycles after a tick, hold 10 cycles, resume. Required: o_sec frozen while paused; next tick exactly 2 counting cycles after resume.
- Wrap: num=1, run 3600 cycles from IDLE. Required: 00:59→01:00 at cycle 60, and 59:59→00:00 at cycle 3600.
- Lap (SW_LAP_EN): at 00:07 pulse i_lap, run 5 ticks, pulse i_lap again. Required: display shows 00:07 throughout LAP, then 00:12 immediately after.
- Simultaneous pulses: i_clear+i_start_stop in RUN → IDLE, zeros, o_run=0. i_start_stop+i_lap in RUN → PAUSE with no lap captured.
- Mid-run reset: rst_n low for one edge during RUN. Required: all outputs 0 the next cycle and state IDLE.
